bridge_tx: RTL and testbench
============================

Name: bridge_tx

Overview:
- Return path of the UART debug bridge: converts read responses coming back from the core bus into ASCII hex response lines for the UART transmitter.
- Each bus read response (valid_i with rw_i=0) becomes one line: 'D', DATA_WIDTH/4 uppercase hex digits, CR, LF.
- Sits between the core chain's bus output and uart_tx. Bytes are handed over with a valid/ready handshake.
- Holds one response in a one-deep queue while a line is in flight.

Parameters:
- DATA_WIDTH, 16, bus data width; must be a multiple of 4; hex digit count NDIG = DATA_WIDTH/4.
- PREAMBLE, 8'h44, first byte of every response line ('D').

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- data_i  input  DATA_WIDTH  bus response data.
- rw_i  input  1  bus direction; 0 = read response (transmitted), 1 = write (ignored).
- valid_i  input  1  bus response strobe, single-cycle qualifier.
- byte_o  output  8  ASCII byte to uart_tx.
- byte_valid_o  output  1  byte_o holds a byte to send.
- byte_ready_i  input  1  uart_tx accepts byte_o this cycle.
- busy_o  output  1  high whenever the FSM is not IDLE or the queue is full.
- overflow_o  output  1  one-cycle pulse when a read response is dropped.

Behaviour:
- Reset, sampled when rst_n=0 at a clk edge:
  - State returns to IDLE and the queue is emptied.
  - byte_o=0, byte_valid_o=0, busy_o=0, overflow_o=0 from the following cycle.
  - Reset mid-line abandons the line; no further bytes are sent.
- A transfer occurs when byte_valid_o && byte_ready_i. While byte_valid_o=1 and no transfer has occurred, byte_o must not change and byte_valid_o must not fall.
- A read event is valid_i && !rw_i. valid_i && rw_i is ignored entirely.
- FSM states: IDLE, PRE, DIG, CR, LF.
  - IDLE: on a read event, capture data_i into the shift register and go to PRE. Latency: event at cycle N gives byte_valid_o=1 with byte_o=PREAMBLE at cycle N+1.
  - PRE: on transfer, go to DIG with digit counter = NDIG-1.
  - DIG: byte_o = ASCII of the most significant remaining nibble.
    - Nibbles 0-9 map to 0x30-0x39; nibbles A-F map to 0x41-0x46.
    - On transfer: shift left by 4 and decrement the counter. A transfer with counter = 0 goes to CR.
  - CR: byte_o = 8'h0D; on transfer, go to LF.
  - LF: byte_o = 8'h0A. On transfer:
    - If the queue is full, load the queue word and go to PRE, with no idle bubble.
    - Else if a read event occurs in the same cycle, load data_i and go to PRE.
    - Else go to IDLE.
- Queue, one entry:
  - A read event while not IDLE is written to the queue if it is empty.
  - It is also written if the queue is being drained in that same cycle (LF transfer with queue full); the queue is then refilled.
  - Otherwise the event is dropped and overflow_o=1 for exactly the next cycle.
- Digit order is most significant nibble first. The data captured for a line is never altered by later bus activity.

Decomposition:
- Shared bridge package holds:
  - ASCII constants: PREAMBLE 'D', CR, LF.
  - The FSM state enum.
  - A nibble-to-ASCII function, shared with bridge_rx, which needs the inverse.
- No sub-module required; the one-entry queue stays inline.

Test Plan:
- Read 16'h12AF with byte_ready_i tied 1 -> bytes 44 31 32 41 46 0D 0A on consecutive cycles starting at N+1; then byte_valid_o=0, busy_o=0.
- Write event (rw_i=1, data 16'hFFFF) -> no bytes; busy_o stays 0.
- Read 16'h0000 with byte_ready_i toggling 1-0-1 -> 44 30 30 30 30 0D 0A in order; byte_o stable during every ready=0 stall.
- Read 16'hBEEF, then read 16'h0001 during the digits -> both lines back-to-back; PRE of the second line directly follows the LF transfer with no idle cycle.
- Reads 16'h1111, then 16'h2222 and 16'h3333 during the first line -> lines for 1111 and 2222 only; overflow_o pulses once, one cycle after the 3333 event.
- rst_n=0 for one cycle after the third digit of 16'hCAFE -> byte_valid_o=0 the next cycle, no CR/LF sent; a new read 16'h0042 afterwards yields a full correct line.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared definitions for the UART debug bridge: ASCII framing bytes, TX FSM states, hex digit encoding.
package bridge_pkg;

    localparam logic [7:0] ASCII_PRE = 8'h44;
    localparam logic [7:0] ASCII_CR  = 8'h0D;
    localparam logic [7:0] ASCII_LF  = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_DIG,
        ST_CR,
        ST_LF
    } state_t;

    // bridge_rx performs the inverse mapping on incoming command lines.
    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return {4'h3, nib};
        else
            return {4'h0, nib} + 8'h37;
    endfunction

endpackage

// File: rtl/bridge_tx.sv
// Formats bus read responses as "D<hex>\r\n" lines for uart_tx, one-deep response queue.
// Latency: read event in cycle N presents the preamble byte in cycle N+1.
// Backpressure: byte_o holds until byte_ready_i; reads beyond line+queue are dropped with overflow_o.
module bridge_tx
    import bridge_pkg::*;
#(
    parameter int         DATA_WIDTH = 16,
    parameter logic [7:0] PREAMBLE   = ASCII_PRE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  rw_i,
    input  logic                  valid_i,
    output logic [7:0]            byte_o,
    output logic                  byte_valid_o,
    input  logic                  byte_ready_i,
    output logic                  busy_o,
    output logic                  overflow_o
);

    localparam int NDIG = DATA_WIDTH / 4;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(NDIG - 1);

    state_t                state_q, state_nxt;
    logic [DATA_WIDTH-1:0] sh_q, sh_nxt;
    logic [CW-1:0]         cnt_q, cnt_nxt;
    logic                  q_vld_q, q_vld_nxt;
    logic [DATA_WIDTH-1:0] q_dat_q, q_dat_nxt;
    logic                  ovf_q, ovf_nxt;
    logic                  xfer, rd_ev, drain, direct;

    assign rd_ev        = valid_i && !rw_i;
    assign byte_valid_o = (state_q != ST_IDLE);
    assign xfer         = byte_valid_o && byte_ready_i;
    assign busy_o       = byte_valid_o || q_vld_q;
    assign overflow_o   = ovf_q;

    always_comb begin
        byte_o = 8'h00;
        case (state_q)
            ST_PRE:  byte_o = PREAMBLE;
            ST_DIG:  byte_o = nib2ascii(sh_q[DATA_WIDTH-1 -: 4]);
            ST_CR:   byte_o = ASCII_CR;
            ST_LF:   byte_o = ASCII_LF;
            default: byte_o = 8'h00;
        endcase
    end

    always_comb begin
        state_nxt = state_q;
        sh_nxt    = sh_q;
        cnt_nxt   = cnt_q;
        q_vld_nxt = q_vld_q;
        q_dat_nxt = q_dat_q;
        ovf_nxt   = 1'b0;
        drain     = 1'b0;
        direct    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rd_ev) begin
                    sh_nxt    = data_i;
                    state_nxt = ST_PRE;
                end
            end
            ST_PRE: begin
                if (xfer) begin
                    state_nxt = ST_DIG;
                    cnt_nxt   = CNT_TOP;
                end
            end
            ST_DIG: begin
                if (xfer) begin
                    sh_nxt  = sh_q << 4;
                    cnt_nxt = cnt_q - CW'(1);
                    if (cnt_q == '0)
                        state_nxt = ST_CR;
                end
            end
            ST_CR: begin
                if (xfer)
                    state_nxt = ST_LF;
            end
            ST_LF: begin
                // Queued response wins over a same-cycle read; the read then refills the queue.
                if (xfer) begin
                    if (q_vld_q) begin
                        drain     = 1'b1;
                        sh_nxt    = q_dat_q;
                        state_nxt = ST_PRE;
                    end else if (rd_ev) begin
                        direct    = 1'b1;
                        sh_nxt    = data_i;
                        state_nxt = ST_PRE;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (drain)
            q_vld_nxt = 1'b0;
        if (rd_ev && (state_q != ST_IDLE) && !direct) begin
            if (!q_vld_q || drain) begin
                q_vld_nxt = 1'b1;
                q_dat_nxt = data_i;
            end else begin
                ovf_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            q_vld_q <= 1'b0;
            q_dat_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_nxt;
            sh_q    <= sh_nxt;
            cnt_q   <= cnt_nxt;
            q_vld_q <= q_vld_nxt;
            q_dat_q <= q_dat_nxt;
            ovf_q   <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_bridge_tx.sv
// Bench for bridge_tx: vector table, hand-written corner sequences, randomized traffic against a line/capacity model.
module tb_bridge_tx;

    localparam int DW   = 16;
    localparam int NDIG = DW / 4;
    localparam int LEN  = NDIG + 3;

    typedef struct {
        logic [15:0]  dat;
        logic         rw;
        int           rmode;
        int           nb;
        logic [111:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          rw_i = 1'b0;
    logic          valid_i = 1'b0;
    logic [7:0]    byte_o;
    logic          byte_valid_o;
    logic          byte_ready_i = 1'b1;
    logic          busy_o;
    logic          overflow_o;

    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  rmode = 0;
    bit  mon_on = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    int         got_cyc[$];
    int         ovf_cyc[$];
    int         occ = 0;
    int         sent = 0;
    bit         ovf_exp = 1'b0;
    bit         busy_seen = 1'b0;
    bit         p_vld = 1'b0, p_rdy = 1'b0, p_rst = 1'b0;
    logic [7:0] p_byte = 8'h00;

    vec_t vt[5];
    int   n0, e3;

    always #5 clk = ~clk;

    bridge_tx #(.DATA_WIDTH(DW), .PREAMBLE(8'h44)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .data_i      (data_i),
        .rw_i        (rw_i),
        .valid_i     (valid_i),
        .byte_o      (byte_o),
        .byte_valid_o(byte_valid_o),
        .byte_ready_i(byte_ready_i),
        .busy_o      (busy_o),
        .overflow_o  (overflow_o)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rmode)
            1:       byte_ready_i = ~byte_ready_i;
            2:       byte_ready_i = 1'($urandom_range(0, 1));
            default: byte_ready_i = 1'b1;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic void push_line(input logic [DW-1:0] w);
        int n;
        exp_q.push_back(8'h44);
        for (int i = NDIG - 1; i >= 0; i--) begin
            n = int'((w >> (4 * i)) & 16'hF);
            exp_q.push_back(n < 10 ? 8'(48 + n) : 8'(55 + n));
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endfunction

    // Model: a response is accepted while fewer than two lines (one sending, one waiting) are outstanding.
    always @(negedge clk) begin
        bit xf, lf_now, rd;
        if (mon_on) begin
            xf = byte_valid_o && byte_ready_i;
            lf_now = 1'b0;
            if (p_vld && !p_rdy && p_rst) begin
                chk("hold_byte", 64'(byte_o), 64'(p_byte));
                chk("hold_valid", 64'(byte_valid_o), 64'(1));
            end
            chk("overflow", 64'(overflow_o), 64'(ovf_exp));
            if (overflow_o) ovf_cyc.push_back(cyc);
            if (busy_o) busy_seen = 1'b1;
            ovf_exp = 1'b0;
            if (xf) begin
                got.push_back(byte_o);
                got_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL stream: unexpected byte %h, none required", byte_o);
                end else begin
                    chk("stream", 64'(byte_o), 64'(exp_q.pop_front()));
                end
                sent++;
                if (sent == LEN) begin
                    lf_now = 1'b1;
                    sent = 0;
                end
            end
            rd = valid_i && !rw_i;
            if (!rst_n) begin
                exp_q.delete();
                occ = 0;
                sent = 0;
            end else begin
                if (rd) begin
                    if (occ - int'(lf_now) < 2) begin
                        push_line(data_i);
                        occ++;
                    end else begin
                        ovf_exp = 1'b1;
                    end
                end
                if (lf_now) occ--;
            end
            p_vld = byte_valid_o;
            p_rdy = byte_ready_i;
            p_rst = rst_n;
            p_byte = byte_o;
        end
    end

    task automatic send(input logic [15:0] d, input logic rw);
        data_i = d;
        rw_i = rw;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        rw_i = 1'b0;
    endtask

    task automatic wait_done(input int nb);
        int w = 0;
        while ((busy_o || got.size() < nb) && w < 400) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 400) begin
            tests++;
            fails++;
            $display("FAIL timeout: got %0d bytes, required %0d with busy low", got.size(), nb);
        end
    endtask

    task automatic cmp_line(input string nm, input logic [111:0] e, input int nb);
        chk({nm, "_count"}, 64'(got.size()), 64'(nb));
        for (int i = 0; i < nb; i++)
            chk(nm, 64'(i < got.size() ? got[i] : 8'hXX), 64'(e[8 * (nb - 1 - i) +: 8]));
    endtask

    task automatic clear_obs();
        got.delete();
        got_cyc.delete();
        ovf_cyc.delete();
        busy_seen = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{dat: 16'h12AF, rw: 1'b0, rmode: 0, nb: 7, exp: 112'h44313241460D0A};
        vt[1] = '{dat: 16'hFFFF, rw: 1'b1, rmode: 0, nb: 0, exp: 112'h0};
        vt[2] = '{dat: 16'h0000, rw: 1'b0, rmode: 1, nb: 7, exp: 112'h44303030300D0A};
        vt[3] = '{dat: 16'h7E5A, rw: 1'b0, rmode: 2, nb: 7, exp: 112'h44374535410D0A};
        vt[4] = '{dat: 16'h9C5D, rw: 1'b0, rmode: 0, nb: 7, exp: 112'h44394335440D0A};

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        mon_on = 1'b1;
        @(negedge clk);
        chk("rst_byte", 64'(byte_o), 64'(0));
        chk("rst_valid", 64'(byte_valid_o), 64'(0));
        chk("rst_busy", 64'(busy_o), 64'(0));
        chk("rst_ovf", 64'(overflow_o), 64'(0));

        for (int v = 0; v < 5; v++) begin
            rmode = vt[v].rmode;
            @(posedge clk); #1;
            clear_obs();
            n0 = cyc;
            send(vt[v].dat, vt[v].rw);
            wait_done(vt[v].nb);
            repeat (4) @(posedge clk);
            #1;
            cmp_line("vec_line", vt[v].exp, vt[v].nb);
            chk("vec_idle_valid", 64'(byte_valid_o), 64'(0));
            chk("vec_idle_busy", 64'(busy_o), 64'(0));
            if (vt[v].rw)
                chk("write_busy", 64'(busy_seen), 64'(0));
            if (vt[v].rmode == 0 && vt[v].nb > 0) begin
                chk("first_latency", 64'(got_cyc[0]), 64'(n0 + 1));
                chk("last_cycle", 64'(got_cyc[vt[v].nb - 1]), 64'(n0 + vt[v].nb));
            end
        end

        // Second read arrives mid-line and must follow the LF with no idle cycle.
        rmode = 0;
        @(posedge clk); #1;
        clear_obs();
        send(16'hBEEF, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        send(16'h0001, 1'b0);
        wait_done(14);
        cmp_line("b2b_line", 112'h44424545460D0A44303030310D0A, 14);
        chk("b2b_span", 64'(got_cyc.size() == 14 ? got_cyc[13] - got_cyc[0] : -1), 64'(13));
        chk("b2b_gap", 64'(got_cyc.size() == 14 ? got_cyc[7] - got_cyc[6] : -1), 64'(1));

        // Third read while one line is sending and one is queued is dropped.
        @(posedge clk); #1;
        clear_obs();
        send(16'h1111, 1'b0);
        send(16'h2222, 1'b0);
        e3 = cyc;
        send(16'h3333, 1'b0);
        wait_done(14);
        repeat (3) @(posedge clk);
        #1;
        cmp_line("ovf_line", 112'h44313131310D0A44323232320D0A, 14);
        chk("ovf_pulses", 64'(ovf_cyc.size()), 64'(1));
        chk("ovf_cycle", 64'(ovf_cyc.size() > 0 ? ovf_cyc[0] : -1), 64'(e3 + 1));

        // Reset in the middle of a line abandons it.
        @(posedge clk); #1;
        clear_obs();
        send(16'hCAFE, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", 64'(byte_valid_o), 64'(0));
        chk("rst_mid_busy", 64'(busy_o), 64'(0));
        repeat (5) @(posedge clk);
        #1;
        cmp_line("rst_mid_line", 112'h44434146, 4);
        clear_obs();
        send(16'h0042, 1'b0);
        wait_done(7);
        cmp_line("post_rst_line", 112'h44303034320D0A, 7);

        // Randomized traffic, random backpressure and rare resets, checked by the monitor model.
        rmode = 2;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk); #1;
            rst_n = ($urandom_range(0, 499) != 0);
            valid_i = ($urandom_range(0, 5) == 0);
            rw_i = ($urandom_range(0, 3) == 0);
            data_i = 16'($urandom);
        end
        valid_i = 1'b0;
        rw_i = 1'b0;
        rst_n = 1'b1;
        rmode = 0;
        @(posedge clk); #1;
        wait_done(0);
        repeat (2) @(posedge clk);
        #1;
        chk("rand_drained", 64'(exp_q.size()), 64'(0));
        chk("rand_idle", 64'(busy_o), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
